// File: rtl/fixed_divider_if.sv
// fixed_divider_if: operand/result valid-ready bundle for fixed_divider.
interface fixed_divider_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, out_valid, out_ready, overflow, div_by_zero;
  logic [WIDTH-1:0] operand_a, operand_b, div_result;
  modport master(output in_valid, operand_a, operand_b, out_ready,
                 input in_ready, out_valid, div_result, overflow, div_by_zero);
  modport slave(input in_valid, operand_a, operand_b, out_ready,
                output in_ready, out_valid, div_result, overflow, div_by_zero);
endinterface

// File: rtl/fixed_divider.sv
// fixed_divider: sequential signed Q(INTEGERWIDTH.FRACTIONWIDTH) restoring divider, one quotient bit per cycle.
// Define DIVIDER_SATURATE_EN to clamp overflowing quotients instead of wrapping them.
module fixed_divider #(
  parameter int WIDTH = 8,
  parameter int INTEGERWIDTH = 4,
  parameter int FRACTIONWIDTH = 4
) (
  input logic clk,
  input logic rst,
  fixed_divider_if.slave bus
);
  localparam int Q = INTEGERWIDTH + 2 * FRACTIONWIDTH;
  localparam int CW = $clog2(Q + 1);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic neg, rdy, vld, ovf_r, dbz;
  logic [WIDTH-1:0] dvs, rem, result, abs_a, abs_b, diff, wrap, res;
  logic [CW-1:0] cnt;
  logic [Q-1:0] quo, quo_next;
  logic [WIDTH:0] trial;
  logic bit_q, ovf;
  assign abs_a = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
  // quo doubles as the dividend shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign trial = {rem, quo[Q-1]};
  assign bit_q = trial >= {1'b0, dvs};
  assign diff = trial[WIDTH-1:0] - dvs;
  assign quo_next = {quo[Q-2:0], bit_q};
  assign ovf = neg ? quo_next > Q'({1'b0, MIN}) : quo_next > Q'(MAX);
  assign wrap = neg ? -quo_next[WIDTH-1:0] : quo_next[WIDTH-1:0];
`ifdef DIVIDER_SATURATE_EN
  assign res = ovf ? (neg ? MIN : MAX) : wrap;
`else
  assign res = wrap;
`endif
  assign bus.in_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.div_result = result;
  assign bus.overflow = ovf_r;
  assign bus.div_by_zero = dbz;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy <= 1'b1;
      vld <= 1'b0;
      result <= '0;
      ovf_r <= 1'b0;
      dbz <= 1'b0;
      neg <= 1'b0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          neg <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          dvs <= abs_b;
          rem <= '0;
          quo <= {abs_a, {FRACTIONWIDTH{1'b0}}};
          cnt <= '0;
          rdy <= 1'b0;
          if (bus.operand_b == '0) begin
            state <= DONE;
            vld <= 1'b1;
            dbz <= 1'b1;
            ovf_r <= 1'b0;
            result <= bus.operand_a[WIDTH-1] ? MIN : MAX;
          end else state <= BUSY;
        end
        BUSY: begin
          rem <= bit_q ? diff : trial[WIDTH-1:0];
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(Q - 1)) begin
            state <= DONE;
            vld <= 1'b1;
            result <= res;
            ovf_r <= ovf;
            dbz <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          vld <= 1'b0;
          rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_divider.sv
// tb_fixed_divider: directed vectors, handshake/reset sequences and randomized checks against an arithmetic model.
`timescale 1ns/1ps
module tb_fixed_divider;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fixed_divider_if #(.WIDTH(8)) bus();
  fixed_divider #(.WIDTH(8), .INTEGERWIDTH(4), .FRACTIONWIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
`ifdef DIVIDER_SATURATE_EN
  localparam logic [7:0] R_7025 = 8'h7F, R_80F0 = 8'h7F;
`else
  localparam logic [7:0] R_7025 = 8'hC0, R_80F0 = 8'h80;
`endif
  typedef struct {logic [7:0] a, b, r; logic o, z; int lat;} vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model(input logic [7:0] a, b, output logic [7:0] r, output logic o, z);
    int sa, sb, mag, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    z = (sb == 0);
    o = 0;
    if (z) r = sa >= 0 ? 8'h7F : 8'h80;
    else begin
      mag = (sa < 0 ? -sa : sa) * 16 / (sb < 0 ? -sb : sb);
      v = ((sa < 0) != (sb < 0)) ? -mag : mag;
      o = v > 127 || v < -128;
`ifdef DIVIDER_SATURATE_EN
      r = o ? (v > 0 ? 8'h7F : 8'h80) : 8'(v);
`else
      r = 8'(v);
`endif
    end
  endfunction
  task automatic start(input logic [7:0] a, b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) chk("out_valid_timeout", 0, 1);
  endtask
  task automatic release_result;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("in_ready_after_xfer", int'(bus.in_ready), 1);
  endtask
  task automatic check_result(input string tag, input logic [7:0] r, input logic o, z);
    chk({tag, "_result"}, int'(bus.div_result), int'(r));
    chk({tag, "_overflow"}, int'(bus.overflow), int'(o));
    chk({tag, "_dbz"}, int'(bus.div_by_zero), int'(z));
  endtask
  initial begin
    int lat, hold;
    logic [7:0] a, b, r;
    logic o, z;
    vecs[0] = '{8'h30, 8'h18, 8'h20, 0, 0, 12};
    vecs[1] = '{8'hD8, 8'h20, 8'hEC, 0, 0, 12};
    vecs[2] = '{8'h10, 8'h30, 8'h05, 0, 0, 12};
    vecs[3] = '{8'hF0, 8'h30, 8'hFB, 0, 0, 12};
    vecs[4] = '{8'h70, 8'h04, R_7025, 1, 0, 12};
    vecs[5] = '{8'h80, 8'hF0, R_80F0, 1, 0, 12};
    vecs[6] = '{8'h80, 8'h10, 8'h80, 0, 0, 12};
    vecs[7] = '{8'h10, 8'h00, 8'h7F, 0, 1, 0};
    vecs[8] = '{8'hF0, 8'h00, 8'h80, 0, 1, 0};
    bus.in_valid = 0; bus.out_ready = 0; bus.operand_a = 0; bus.operand_b = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    check_result("rst", 8'h00, 0, 0);
    // lat counts edges after the acceptance edge; a zero divisor is valid on the very next cycle
    for (int i = 0; i < 9; i++) begin
      start(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check_result($sformatf("vec%0d", i), vecs[i].r, vecs[i].o, vecs[i].z);
      release_result();
    end
    start(8'h30, 8'h18);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.operand_a = 8'h70; bus.operand_b = 8'h01;
      @(posedge clk); #1;
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      check_result("hold", 8'h20, 0, 0);
    end
    bus.in_valid = 0;
    release_result();
    chk("post_hold_out_valid", int'(bus.out_valid), 0);
    start(8'h30, 8'h18);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    check_result("abort", 8'h00, 0, 0);
    start(8'h30, 8'h18);
    wait_valid(lat);
    chk("fresh_latency", lat, 12);
    check_result("fresh", 8'h20, 0, 0);
    release_result();
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      model(a, b, r, o, z);
      start(a, b);
      wait_valid(lat);
      chk($sformatf("rand%0d_%02h_%02h_latency", i, a, b), lat, z ? 0 : 12);
      hold = $urandom_range(0, 3);
      for (int k = 0; k <= hold; k++) begin
        check_result($sformatf("rand%0d_%02h_%02h", i, a, b), r, o, z);
        if (k < hold) begin @(posedge clk); #1; end
      end
      release_result();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
